// File: rtl/beams_pick_pkg.sv
// beams_pick_pkg: shared types and default sizes for the successor beam picker.
// Holds beam/lane vector types and the read-side FSM state encoding.
package beams_pick_pkg;

  localparam int NUM_BEAMS = 32;
  localparam int NUM_PICK  = 16;
  localparam int DATA_W    = 40;
  localparam int PWR_W     = 32;
  localparam int IDX_W     = $clog2(NUM_BEAMS) + 1;

  typedef logic [NUM_BEAMS-1:0][DATA_W-1:0] beam_vec_t;
  typedef logic [NUM_PICK-1:0][DATA_W-1:0]  pick_vec_t;
  typedef logic [NUM_PICK-1:0][PWR_W-1:0]   pwr_vec_t;
  typedef logic [NUM_PICK-1:0][IDX_W-1:0]   idx_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_IDX,
    READ
  } rd_state_t;

endpackage

// File: rtl/beams_pick_pp_ram.sv
// beams_pick_pp_ram: two simple-dual-port banks with registered read.
// Ports: clk; write en/bank/addr/data; read en/bank/addr; rd_data (1-cycle latency).
module beams_pick_pp_ram #(
  parameter int W      = 2560,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [W-1:0]      wr_data,
  input  logic              rd_en,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [W-1:0]      rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [W-1:0] mem0 [DEPTH];
  logic [W-1:0] mem1 [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en && !wr_bank)
      mem0[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (wr_en && wr_bank)
      mem1[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en)
      rd_data <= rd_bank ? mem1[rd_addr]
                         : mem0[rd_addr];
  end

endmodule

// File: rtl/beams_pick_gen.sv
// beams_pick_gen: buffers a packet of beam vectors, replays NUM_PICK sorted beams.
// In: i_clk, i_reset(async low), write beat bus, sort idx/pwr, i_bypass. Out: picked re/im/pwr, vld/sop/eop, ovf, busy.
module beams_pick_gen #(
  parameter int NUM_BEAMS = beams_pick_pkg::NUM_BEAMS,
  parameter int NUM_PICK  = beams_pick_pkg::NUM_PICK,
  parameter int DATA_W    = beams_pick_pkg::DATA_W,
  parameter int PWR_W     = beams_pick_pkg::PWR_W,
  parameter int ADDR_W    = 11,
  localparam int IDX_W    = $clog2(NUM_BEAMS) + 1
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_wr_vld,
  input  logic                        i_wr_sop,
  input  logic                        i_wr_eop,
  input  logic [NUM_BEAMS*DATA_W-1:0] i_wr_re,
  input  logic [NUM_BEAMS*DATA_W-1:0] i_wr_im,
  input  logic                        i_sym_1st,
  input  logic                        i_sort_vld,
  input  logic [NUM_PICK*IDX_W-1:0]   i_sort_idx,
  input  logic [NUM_PICK*PWR_W-1:0]   i_sort_pwr,
  input  logic                        i_bypass,
  output logic [NUM_PICK*DATA_W-1:0]  o_re,
  output logic [NUM_PICK*DATA_W-1:0]  o_im,
  output logic [NUM_PICK*PWR_W-1:0]   o_pwr,
  output logic                        o_vld,
  output logic                        o_sop,
  output logic                        o_eop,
  output logic                        o_ovf,
  output logic                        o_busy
);

  import beams_pick_pkg::*;

  localparam int BW = NUM_BEAMS * DATA_W;
  localparam int LW = ADDR_W + 1;

  typedef logic [NUM_PICK-1:0][IDX_W-1:0]   lidx_t;
  typedef logic [NUM_PICK-1:0][PWR_W-1:0]   lpwr_t;
  typedef logic [NUM_PICK-1:0][DATA_W-1:0]  lane_t;
  typedef logic [NUM_BEAMS-1:0][DATA_W-1:0] beams_t;

  // write side
  logic              wr_bank;
  logic              wr_act;
  logic [LW-1:0]     wa;
  logic [1:0]        bank_full;
  logic [1:0]        bank_sym1;
  logic [1:0][LW-1:0] bank_len;

  logic              sop_ok;
  logic              sop_drop;
  logic              beat_ok;
  logic              wr_en;
  logic              wr_eop;
  logic [ADDR_W-1:0] wr_addr;
  logic [LW-1:0]     wr_len;

  // read side
  rd_state_t         state;
  logic              rd_bank;
  logic              fresh;
  logic              loaded;
  logic [LW-1:0]     ra;
  logic              rd_done;
  logic              start;
  lidx_t             idx_r;
  lpwr_t             pwr_r;
  lidx_t             snap_idx;
  lpwr_t             snap_pwr;
  lidx_t             src_idx;
  lpwr_t             src_pwr;
  lidx_t             nxt_idx;
  lpwr_t             nxt_pwr;

  // pipeline
  logic [2*BW-1:0]   rd_data;
  beams_t            rd_re;
  beams_t            rd_im;
  lane_t             lane_re;
  lane_t             lane_im;
  logic              p1_vld;
  logic              p1_sop;
  logic              p1_eop;
  lane_t             out_re;
  lane_t             out_im;
  lpwr_t             out_pwr;

  // wa counts beats stored so far; its MSB set means the bank is full
  always_comb begin
    sop_drop = i_wr_vld & i_wr_sop & bank_full[wr_bank];
    sop_ok   = i_wr_vld & i_wr_sop & ~bank_full[wr_bank];
    beat_ok  = sop_ok | (i_wr_vld & ~i_wr_sop & wr_act);
    wr_en    = beat_ok & (sop_ok | ~wa[ADDR_W]);
    wr_addr  = sop_ok ? '0 : wa[ADDR_W-1:0];
    wr_eop   = beat_ok & i_wr_eop;
    wr_len   = sop_ok ? LW'(1) : wa + LW'(wr_en);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_bank   <= 1'b0;
      wr_act    <= 1'b0;
      wa        <= '0;
      bank_full <= '0;
      bank_sym1 <= '0;
      bank_len  <= '0;
    end else begin
      if (sop_ok) begin
        wa                 <= LW'(1);
        wr_act             <= ~i_wr_eop;
        bank_sym1[wr_bank] <= i_sym_1st;
      end else if (sop_drop) begin
        wr_act <= 1'b0;
      end else if (beat_ok) begin
        if (wr_en)
          wa <= wa + LW'(1);
        if (i_wr_eop)
          wr_act <= 1'b0;
      end
      if (wr_eop) begin
        wr_bank           <= ~wr_bank;
        bank_len[wr_bank] <= wr_len;
      end
      for (int b = 0; b < 2; b++) begin
        if (wr_eop && wr_bank == 1'(b))
          bank_full[b] <= 1'b1;
        else if (rd_done && rd_bank == 1'(b))
          bank_full[b] <= 1'b0;
      end
    end
  end

  beams_pick_pp_ram #(
    .W      (2 * BW),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (i_clk),
    .wr_en   (wr_en),
    .wr_bank (wr_bank),
    .wr_addr (wr_addr),
    .wr_data ({i_wr_im, i_wr_re}),
    .rd_en   (state == READ),
    .rd_bank (rd_bank),
    .rd_addr (ra[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  assign rd_done = (state == READ) &&
                   (ra == bank_len[rd_bank] - LW'(1));

  // snapshot taken at READ entry; a same-cycle sort pulse wins
  always_comb begin
    src_idx = i_sort_vld ? i_sort_idx : idx_r;
    src_pwr = i_sort_vld ? i_sort_pwr : pwr_r;
    for (int k = 0; k < NUM_PICK; k++) begin
      nxt_idx[k] = i_bypass ? IDX_W'(k) : src_idx[k];
      nxt_pwr[k] = src_pwr[k];
      if (i_bypass || nxt_idx[k][IDX_W-1])
        nxt_pwr[k] = '0;
    end
  end

  always_comb begin
    start = 1'b0;
    unique case (state)
      IDLE:
        start = bank_full[rd_bank] &
                (i_bypass | (~bank_sym1[rd_bank] & loaded));
      WAIT_IDX:
        start = i_bypass | fresh | i_sort_vld;
      default:
        start = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      rd_bank  <= 1'b0;
      fresh    <= 1'b0;
      loaded   <= 1'b0;
      ra       <= '0;
      idx_r    <= '0;
      pwr_r    <= '0;
      snap_idx <= '0;
      snap_pwr <= '0;
    end else begin
      if (i_sort_vld) begin
        idx_r  <= i_sort_idx;
        pwr_r  <= i_sort_pwr;
        fresh  <= 1'b1;
        loaded <= 1'b1;
      end
      if (start) begin
        state    <= READ;
        ra       <= '0;
        snap_idx <= nxt_idx;
        snap_pwr <= nxt_pwr;
        fresh    <= 1'b0;
      end else begin
        unique case (state)
          IDLE:
            if (bank_full[rd_bank])
              state <= WAIT_IDX;
          WAIT_IDX:
            state <= WAIT_IDX;
          READ: begin
            ra <= ra + LW'(1);
            if (rd_done) begin
              state   <= IDLE;
              rd_bank <= ~rd_bank;
            end
          end
          default:
            state <= IDLE;
        endcase
      end
    end
  end

  assign rd_re = rd_data[BW-1:0];
  assign rd_im = rd_data[2*BW-1:BW];

  always_comb begin
    for (int k = 0; k < NUM_PICK; k++) begin
      lane_re[k] = '0;
      lane_im[k] = '0;
      if (!snap_idx[k][IDX_W-1]) begin
        lane_re[k] = rd_re[snap_idx[k][IDX_W-2:0]];
        lane_im[k] = rd_im[snap_idx[k][IDX_W-2:0]];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      p1_vld  <= 1'b0;
      p1_sop  <= 1'b0;
      p1_eop  <= 1'b0;
      o_vld   <= 1'b0;
      o_sop   <= 1'b0;
      o_eop   <= 1'b0;
      out_re  <= '0;
      out_im  <= '0;
      out_pwr <= '0;
    end else begin
      p1_vld <= (state == READ);
      p1_sop <= (state == READ) && (ra == '0);
      p1_eop <= rd_done;
      o_vld  <= p1_vld;
      o_sop  <= p1_sop;
      o_eop  <= p1_eop;
      if (p1_vld) begin
        out_re  <= lane_re;
        out_im  <= lane_im;
        out_pwr <= snap_pwr;
      end
    end
  end

  assign o_re   = out_re;
  assign o_im   = out_im;
  assign o_pwr  = out_pwr;
  assign o_ovf  = sop_drop;
  assign o_busy = (|bank_full) | (state == READ);

endmodule

// File: tb/tb_beams_pick_gen.sv
// tb_beams_pick_gen: directed scoreboard bench for beams_pick_gen.
// Expected beats are queued when packets are driven and popped on o_vld.
module tb_beams_pick_gen;

  localparam int NB = 32;
  localparam int NP = 16;
  localparam int DW = 40;
  localparam int PW = 32;
  localparam int AW = 3;
  localparam int IW = 6;
  localparam int CW = NP * DW;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b0;
  logic              i_wr_vld = 1'b0;
  logic              i_wr_sop = 1'b0;
  logic              i_wr_eop = 1'b0;
  logic [NB*DW-1:0]  i_wr_re = '0;
  logic [NB*DW-1:0]  i_wr_im = '0;
  logic              i_sym_1st = 1'b0;
  logic              i_sort_vld = 1'b0;
  logic [NP*IW-1:0]  i_sort_idx = '0;
  logic [NP*PW-1:0]  i_sort_pwr = '0;
  logic              i_bypass = 1'b0;
  logic [NP*DW-1:0]  o_re;
  logic [NP*DW-1:0]  o_im;
  logic [NP*PW-1:0]  o_pwr;
  logic              o_vld;
  logic              o_sop;
  logic              o_eop;
  logic              o_ovf;
  logic              o_busy;

  beams_pick_gen #(.ADDR_W(AW)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_wr_vld   (i_wr_vld),
    .i_wr_sop   (i_wr_sop),
    .i_wr_eop   (i_wr_eop),
    .i_wr_re    (i_wr_re),
    .i_wr_im    (i_wr_im),
    .i_sym_1st  (i_sym_1st),
    .i_sort_vld (i_sort_vld),
    .i_sort_idx (i_sort_idx),
    .i_sort_pwr (i_sort_pwr),
    .i_bypass   (i_bypass),
    .o_re       (o_re),
    .o_im       (o_im),
    .o_pwr      (o_pwr),
    .o_vld      (o_vld),
    .o_sop      (o_sop),
    .o_eop      (o_eop),
    .o_ovf      (o_ovf),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [NP*DW-1:0] re;
    logic [NP*DW-1:0] im;
    logic [NP*PW-1:0] pwr;
    logic             sop;
    logic             eop;
  } beat_t;

  beat_t q[$];
  int errors = 0;
  int checks = 0;
  int ovf_cnt = 0;
  int cyc = 0;
  int last_eop = 0;
  bit have_eop = 0;
  bit gap_en = 0;
  int cur_idx[NP];
  int cur_pwr[NP];

  task automatic chk(string tag, logic [CW-1:0] obs, logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] bval(int p, int a, int b, bit im);
    logic [DW-1:0] v;
    v = DW'(b + 256 * a + 65536 * p);
    if (im)
      v = v ^ 40'hF0_0000_0000;
    return v;
  endfunction

  always @(posedge i_clk) cyc++;

  always @(negedge i_clk) begin
    beat_t e;
    if (o_ovf)
      ovf_cnt++;
    if (o_vld) begin
      chk("beat_expected", 640'(q.size() != 0), 640'(1));
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("re", o_re, e.re);
        chk("im", o_im, e.im);
        chk("pwr", 640'(o_pwr), 640'(e.pwr));
        chk("sop", 640'(o_sop), 640'(e.sop));
        chk("eop", 640'(o_eop), 640'(e.eop));
      end
      if (gap_en && o_sop && have_eop)
        chk("b2b_gap", 640'((cyc - last_eop) <= 2), 640'(1));
      if (o_eop) begin
        last_eop = cyc;
        have_eop = 1;
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_pkt(int p, int n, bit sym1);
    for (int a = 0; a < n; a++) begin
      i_wr_vld  = 1'b1;
      i_wr_sop  = (a == 0);
      i_wr_eop  = (a == n - 1);
      i_sym_1st = (a == 0) ? sym1 : 1'b0;
      for (int b = 0; b < NB; b++) begin
        i_wr_re[b*DW +: DW] = bval(p, a, b, 1'b0);
        i_wr_im[b*DW +: DW] = bval(p, a, b, 1'b1);
      end
      tick();
    end
    i_wr_vld = 1'b0;
    i_wr_sop = 1'b0;
    i_wr_eop = 1'b0;
  endtask

  task automatic send_sort();
    for (int k = 0; k < NP; k++) begin
      i_sort_idx[k*IW +: IW] = IW'(cur_idx[k]);
      i_sort_pwr[k*PW +: PW] = PW'(cur_pwr[k]);
    end
    i_sort_vld = 1'b1;
    tick();
    i_sort_vld = 1'b0;
  endtask

  task automatic push_exp(int p, int n, bit byp);
    beat_t e;
    int id;
    for (int a = 0; a < n; a++) begin
      for (int k = 0; k < NP; k++) begin
        id = byp ? k : cur_idx[k];
        if (id >= NB) begin
          e.re[k*DW +: DW]  = '0;
          e.im[k*DW +: DW]  = '0;
          e.pwr[k*PW +: PW] = '0;
        end else begin
          e.re[k*DW +: DW]  = bval(p, a, id, 1'b0);
          e.im[k*DW +: DW]  = bval(p, a, id, 1'b1);
          e.pwr[k*PW +: PW] = byp ? '0 : PW'(cur_pwr[k]);
        end
      end
      e.sop = (a == 0);
      e.eop = (a == n - 1);
      q.push_back(e);
    end
  endtask

  task automatic drain(string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 640'(q.size()), 640'(0));
    repeat (3) tick();
  endtask

  task automatic wait_vld(output int n);
    n = 0;
    while (!o_vld && n < 20) begin
      @(negedge i_clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) tick();
    chk("rst_vld", 640'(o_vld), 640'(0));
    chk("rst_flags", 640'({o_sop, o_eop, o_ovf, o_busy}), 640'(0));
    chk("rst_re", o_re, '0);
    chk("rst_im", o_im, '0);
    chk("rst_pwr", 640'(o_pwr), 640'(0));
    i_reset = 1'b1;
    tick();

    // first symbol: waits for indices, then fixed latency
    for (int k = 0; k < NP; k++) begin
      cur_idx[k] = 31 - k;
      cur_pwr[k] = 1000 + k;
    end
    push_exp(1, 4, 1'b0);
    send_pkt(1, 4, 1'b1);
    repeat (3) tick();
    chk("wait_busy", 640'(o_busy), 640'(1));
    chk("wait_novld", 640'(o_vld), 640'(0));
    send_sort();
    @(negedge i_clk);
    chk("lat_c1", 640'(o_vld), 640'(0));
    @(negedge i_clk);
    chk("lat_c2", 640'(o_vld), 640'(0));
    @(negedge i_clk);
    chk("lat_sop", 640'({o_vld, o_sop}), 640'(2'b11));
    drain("drain1");

    // non-first symbol reuses held indices
    push_exp(2, 4, 1'b0);
    send_pkt(2, 4, 1'b0);
    wait_vld(n);
    chk("immediate_start", 640'(n <= 4), 640'(1));
    drain("drain2");
    chk("no_ovf_yet", 640'(ovf_cnt), 640'(0));

    // three back-to-back packets: third dropped
    for (int k = 0; k < NP; k++) begin
      cur_idx[k] = 2 * k;
      cur_pwr[k] = 2000 + k;
    end
    push_exp(3, 3, 1'b0);
    push_exp(4, 2, 1'b0);
    have_eop = 0;
    gap_en = 1;
    send_pkt(3, 3, 1'b1);
    send_pkt(4, 2, 1'b0);
    send_pkt(5, 2, 1'b0);
    repeat (2) tick();
    send_sort();
    drain("drain3");
    gap_en = 0;
    chk("ovf_once", 640'(ovf_cnt), 640'(1));

    // out-of-range index on lane 5
    for (int k = 0; k < NP; k++) begin
      cur_idx[k] = k + 3;
      cur_pwr[k] = 4000 + k;
    end
    cur_idx[5] = 32;
    push_exp(6, 2, 1'b0);
    send_pkt(6, 2, 1'b1);
    tick();
    send_sort();
    drain("drain4");
    chk("mask_pwr5", 640'(o_pwr[5*PW +: PW]), 640'(0));
    chk("pwr_lane0", 640'(o_pwr[0 +: PW]), 640'(4000));

    // bypass, single beat
    i_bypass = 1'b1;
    push_exp(7, 1, 1'b1);
    send_pkt(7, 1, 1'b1);
    wait_vld(n);
    chk("byp_no_wait", 640'(n <= 4), 640'(1));
    chk("byp_sop_eop", 640'({o_sop, o_eop}), 640'(2'b11));
    drain("drain5");
    i_bypass = 1'b0;

    // overlong packet truncated to bank depth
    push_exp(8, 8, 1'b0);
    send_pkt(8, 10, 1'b0);
    drain("drain6");

    // reset in the middle of a read
    push_exp(9, 8, 1'b0);
    send_pkt(9, 8, 1'b0);
    wait_vld(n);
    tick();
    tick();
    i_reset = 1'b0;
    #1;
    chk("midrst_vld", 640'({o_vld, o_sop, o_eop}), 640'(0));
    chk("midrst_busy", 640'(o_busy), 640'(0));
    chk("midrst_re", o_re, '0);
    chk("midrst_pwr", 640'(o_pwr), 640'(0));
    q.delete();
    tick();
    tick();
    i_reset = 1'b1;
    tick();
    for (int k = 0; k < NP; k++) begin
      cur_idx[k] = k + 16;
      cur_pwr[k] = 3000 + k;
    end
    push_exp(10, 3, 1'b0);
    send_pkt(10, 3, 1'b1);
    tick();
    send_sort();
    drain("drain7");

    chk("q_empty_end", 640'(q.size()), 640'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
